// File: rtl/time_set_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// time_set_ctrl
// Converts three raw push-buttons into a time-set session for the
// seconds-of-day clock. Each button is synchronized, debounced and
// edge-detected. A RUN / SET_MIN / SET_SEC / LOAD state machine then edits the
// minutes and seconds and offers the new elapsed-seconds value to the clock
// counter.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   btn_mode     raw mode button (asynchronous, active-high)
//   btn_inc      raw increment button (asynchronous, active-high)
//   btn_dec      raw decrement button (asynchronous, active-high)
//   cur_elapsed  current seconds of day, 0..86399
//   load_ready   clock counter accepts a load this cycle
//   load_valid   new time is offered
//   load_value   new seconds of day, 0..86399
//   set_active   high in SET_MIN, SET_SEC or LOAD
//   edit_field   0 = none, 1 = minutes, 2 = seconds
//   edit_min     minutes being edited, 0..59
//   edit_sec     seconds being edited, 0..59
//   dbg_state    FSM state: 0 RUN, 1 SET_MIN, 2 SET_SEC, 3 LOAD
//
// Load handshake: load_valid is high for the whole LOAD state and load_value
// is constant while it is high. A transfer happens on a cycle where
// load_valid and load_ready are both high; the following cycle is RUN with
// load_valid low. load_value keeps its last value afterwards.
// -----------------------------------------------------------------------------
module time_set_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TIMEOUT_CYCLES  = 500_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic        btn_dec,
  input  logic [16:0] cur_elapsed,
  input  logic        load_ready,
  output logic        load_valid,
  output logic [16:0] load_value,
  output logic        set_active,
  output logic [1:0]  edit_field,
  output logic [5:0]  edit_min,
  output logic [5:0]  edit_sec,
  output logic [1:0]  dbg_state
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_SET_MIN = 2'd1;
  localparam logic [1:0] ST_SET_SEC = 2'd2;
  localparam logic [1:0] ST_LOAD    = 2'd3;

  // Button index: 0 = mode, 1 = inc, 2 = dec.
  logic [2:0]      w_raw;
  logic [2:0]      r_sync1;
  logic [2:0]      r_sync2;
  logic [2:0]      r_db;
  logic [2:0]      r_db_q;
  logic [DB_W-1:0] r_db_cnt [3];
  logic [2:0]      w_press;

  assign w_raw = {btn_dec, btn_inc, btn_mode};

  // The counter only advances on consecutive mismatching cycles, so a level
  // must be stable for DEBOUNCE_CYCLES before it is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_db_q  <= '0;
      for (int i = 0; i < 3; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_db_q  <= r_db;
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_db[i]     <= ~r_db[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_ONE;
        end
      end
    end
  end

  // One-cycle pulse on a debounced rising edge only.
  assign w_press = r_db & ~r_db_q;

  logic            w_mode;
  logic            w_inc;
  logic            w_dec;
  assign w_mode = w_press[0];
  assign w_inc  = w_press[1];
  assign w_dec  = w_press[2];

  logic [1:0]      r_state;
  logic [4:0]      r_hours;
  logic [5:0]      r_edit_min;
  logic [5:0]      r_edit_sec;
  logic [16:0]     r_load_value;
  logic [TO_W-1:0] r_to_cnt;

  logic [4:0]      w_cap_hours;
  logic [5:0]      w_cap_min;
  logic [5:0]      w_cap_sec;
  logic [16:0]     w_load_sum;

  assign w_cap_hours = 5'(cur_elapsed / 17'd3600);
  assign w_cap_min   = 6'((cur_elapsed / 17'd60) % 17'd60);
  assign w_cap_sec   = 6'(cur_elapsed % 17'd60);
  assign w_load_sum  = {12'd0, r_hours} * 17'd3600
                     + {11'd0, r_edit_min} * 17'd60
                     + {11'd0, r_edit_sec};

  // Modulo-60 step; inc and dec together cancel.
  function automatic logic [5:0] step60(input logic [5:0] v, input logic up,
                                        input logic down);
    logic [5:0] r;
    r = v;
    if (up && !down)      r = (v == 6'd59) ? 6'd0  : v + 6'd1;
    else if (down && !up) r = (v == 6'd0)  ? 6'd59 : v - 6'd1;
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_RUN;
      r_hours      <= '0;
      r_edit_min   <= '0;
      r_edit_sec   <= '0;
      r_load_value <= '0;
      r_to_cnt     <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_mode) begin
            r_hours    <= w_cap_hours;
            r_edit_min <= w_cap_min;
            r_edit_sec <= w_cap_sec;
            r_to_cnt   <= '0;
            r_state    <= ST_SET_MIN;
          end
        end
        ST_SET_MIN, ST_SET_SEC: begin
          // Mode wins over inc/dec arriving in the same cycle.
          if (w_mode) begin
            r_to_cnt <= '0;
            if (r_state == ST_SET_MIN) begin
              r_state <= ST_SET_SEC;
            end else begin
              r_load_value <= w_load_sum;
              r_state      <= ST_LOAD;
            end
          end else if (w_inc || w_dec) begin
            r_to_cnt <= '0;
            if (r_state == ST_SET_MIN) r_edit_min <= step60(r_edit_min, w_inc, w_dec);
            else                       r_edit_sec <= step60(r_edit_sec, w_inc, w_dec);
          end else if (r_to_cnt == TO_LAST) begin
            r_to_cnt <= '0;
            r_state  <= ST_RUN;
          end else begin
            r_to_cnt <= r_to_cnt + TO_ONE;
          end
        end
        ST_LOAD: begin
          if (load_ready) r_state <= ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign load_valid = (r_state == ST_LOAD);
  assign load_value = r_load_value;
  assign set_active = (r_state != ST_RUN);
  assign edit_field = (r_state == ST_RUN)     ? 2'd0 :
                      (r_state == ST_SET_MIN) ? 2'd1 : 2'd2;
  assign edit_min   = r_edit_min;
  assign edit_sec   = r_edit_sec;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_time_set_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_time_set_ctrl
// Directed bench for time_set_ctrl with short debounce/timeout parameters.
// A behavioural model tracks the session from the raw buttons and is compared
// against the DUT outputs on every falling edge; directed steps add literal
// expectations for the documented scenarios.
// -----------------------------------------------------------------------------
module tb_time_set_ctrl;

  localparam int DEB = 4;
  localparam int TMO = 100;

  localparam logic [2:0] B_MODE = 3'b001;
  localparam logic [2:0] B_INC  = 3'b010;
  localparam logic [2:0] B_DEC  = 3'b100;

  logic        clk;
  logic        reset;
  logic        btn_mode;
  logic        btn_inc;
  logic        btn_dec;
  logic [16:0] cur_elapsed;
  logic        load_ready;
  logic        load_valid;
  logic [16:0] load_value;
  logic        set_active;
  logic [1:0]  edit_field;
  logic [5:0]  edit_min;
  logic [5:0]  edit_sec;
  logic [1:0]  dbg_state;

  time_set_ctrl #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .cur_elapsed(cur_elapsed), .load_ready(load_ready),
    .load_valid(load_valid), .load_value(load_value),
    .set_active(set_active), .edit_field(edit_field),
    .edit_min(edit_min), .edit_sec(edit_sec), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int valid_cnt = 0;
  int xfers     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 RUN, 1 editing minutes, 2 editing seconds, 3 offering the load.
  bit         m_valid = 0;
  int         m_phase, m_hours, m_min, m_sec, m_lv, m_idle, m_step, m_nd;
  logic [2:0] m_s1, m_s2, m_acc, m_pend, m_pr;
  logic [2:0] m_hist[$];

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1;
      m_phase = 0; m_hours = 0; m_min = 0; m_sec = 0; m_lv = 0; m_idle = 0;
      m_s1 = '0; m_s2 = '0; m_acc = '0; m_pend = '0;
      m_hist.delete();
    end else begin
      m_pr = m_pend;
      case (m_phase)
        0: if (m_pr[0]) begin
             m_hours = int'(cur_elapsed) / 3600;
             m_min   = (int'(cur_elapsed) / 60) % 60;
             m_sec   = int'(cur_elapsed) % 60;
             m_phase = 1;
             m_idle  = 0;
           end
        1, 2: begin
          if (m_pr[0]) begin
            if (m_phase == 1) m_phase = 2;
            else begin
              m_phase = 3;
              m_lv = m_hours * 3600 + m_min * 60 + m_sec;
            end
            m_idle = 0;
          end else if (m_pr[1] || m_pr[2]) begin
            m_idle = 0;
            if (m_pr[1] && !m_pr[2])      m_step = 1;
            else if (m_pr[2] && !m_pr[1]) m_step = 59;
            else                          m_step = 0;
            if (m_phase == 1) m_min = (m_min + m_step) % 60;
            else              m_sec = (m_sec + m_step) % 60;
          end else begin
            m_idle++;
            if (m_idle >= TMO) begin
              m_phase = 0;
              m_idle  = 0;
            end
          end
        end
        default: if (load_ready) m_phase = 0;
      endcase
      // A level is accepted once the last DEB synchronized samples all
      // disagree with the accepted level; a rising acceptance is a press that
      // acts on the following clock.
      m_hist.push_back(m_s2);
      if (m_hist.size() > DEB) void'(m_hist.pop_front());
      m_pend = '0;
      if (m_hist.size() == DEB) begin
        for (int b = 0; b < 3; b++) begin
          m_nd = 0;
          for (int j = 0; j < DEB; j++) if (m_hist[j][b] != m_acc[b]) m_nd++;
          if (m_nd == DEB) begin
            m_acc[b] = ~m_acc[b];
            if (m_acc[b]) m_pend[b] = 1'b1;
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = {btn_dec, btn_inc, btn_mode};
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      chk("cyc_load_valid", 32'(load_valid), 32'(m_phase == 3));
      chk("cyc_set_active", 32'(set_active), 32'(m_phase != 0));
      chk("cyc_edit_field", 32'(edit_field), (m_phase == 0) ? 0 : (m_phase == 1) ? 1 : 2);
      chk("cyc_edit_min",   32'(edit_min),   m_min);
      chk("cyc_edit_sec",   32'(edit_sec),   m_sec);
      chk("cyc_load_value", 32'(load_value), m_lv);
      chk("cyc_dbg_state",  32'(dbg_state),  m_phase);
    end
    if (load_valid === 1'b1) valid_cnt++;
    if (load_valid === 1'b1 && load_ready === 1'b1) xfers++;
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [2:0] m, input int hold);
    {btn_dec, btn_inc, btn_mode} = m;
    cyc(hold);
    {btn_dec, btn_inc, btn_mode} = 3'b000;
    cyc(10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  int         lat;
  int         xb;
  logic [5:0] start_min;

  initial begin
    reset = 1'b1;
    {btn_dec, btn_inc, btn_mode} = 3'b000;
    cur_elapsed = 17'd0;
    load_ready  = 1'b0;
    cyc(3);
    reset = 1'b0;
    cyc(2);
    chk("rst_load_valid", 32'(load_valid), 0);
    chk("rst_load_value", 32'(load_value), 0);
    chk("rst_set_active", 32'(set_active), 0);
    chk("rst_edit_field", 32'(edit_field), 0);
    chk("rst_edit_min",   32'(edit_min),   0);

    // 1. Full edit session, 01:02:05 -> 01:05:59.
    cur_elapsed = 17'd3725;
    load_ready  = 1'b1;
    press(B_MODE, 8);
    chk("t1_field_min", 32'(edit_field), 1);
    chk("t1_cap_min",   32'(edit_min),   2);
    chk("t1_cap_sec",   32'(edit_sec),   5);
    press(B_INC, 8); press(B_INC, 8); press(B_INC, 8);
    chk("t1_min_5", 32'(edit_min), 5);
    press(B_MODE, 8);
    chk("t1_field_sec", 32'(edit_field), 2);
    for (int i = 0; i < 6; i++) press(B_DEC, 8);
    chk("t1_sec_59", 32'(edit_sec), 59);
    valid_cnt = 0;
    xb = xfers;
    press(B_MODE, 8);
    chk("t1_pulse_len",  32'(valid_cnt), 1);
    chk("t1_xfer",       32'(xfers - xb), 1);
    chk("t1_load_value", 32'(load_value), 3959);
    chk("t1_run",        32'(set_active), 0);
    load_ready = 1'b0;

    // 2. Glitch rejection in SET_MIN.
    press(B_MODE, 8);
    chk("t2_min_2", 32'(edit_min), 2);
    for (int g = 1; g <= 3; g++) begin
      btn_inc = 1'b1;
      cyc(g);
      btn_inc = 1'b0;
      cyc(10);
      chk("t2_glitch", 32'(edit_min), 2);
    end
    start_min = edit_min;
    lat = 0;
    btn_inc = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc(1);
      if (lat == 0 && edit_min != start_min) lat = k;
    end
    btn_inc = 1'b0;
    cyc(10);
    chk("t2_inc_once", 32'(edit_min), 3);
    chk("t2_latency",  32'(lat >= DEB && lat <= DEB + 4), 1);
    cyc(120);
    chk("t2_timeout_run", 32'(edit_field), 0);

    // 3. Wraps and simultaneous presses, starting from 00:59:10.
    cur_elapsed = 17'd3550;
    press(B_MODE, 8);
    chk("t3_min_59", 32'(edit_min), 59);
    press(B_INC, 8);
    chk("t3_wrap_up", 32'(edit_min), 0);
    press(B_DEC, 8);
    chk("t3_wrap_dn", 32'(edit_min), 59);
    press(B_INC | B_DEC, 8);
    chk("t3_incdec_min",   32'(edit_min),   59);
    chk("t3_incdec_field", 32'(edit_field), 1);
    press(B_MODE | B_INC, 8);
    chk("t3_modeinc_field", 32'(edit_field), 2);
    chk("t3_modeinc_min",   32'(edit_min),   59);
    chk("t3_sec_10",        32'(edit_sec),   10);

    // 4. Timeout from SET_SEC.
    valid_cnt = 0;
    cyc(120);
    chk("t4_field",  32'(edit_field), 0);
    chk("t4_active", 32'(set_active), 0);
    chk("t4_novalid", 32'(valid_cnt), 0);
    chk("t4_hold_min", 32'(edit_min), 59);
    chk("t4_hold_sec", 32'(edit_sec), 10);

    // 5. Handshake stall at 23:59:59.
    cur_elapsed = 17'd86399;
    press(B_MODE, 8);
    press(B_MODE, 8);
    press(B_MODE, 8);
    chk("t5_valid",  32'(load_valid), 1);
    chk("t5_value",  32'(load_value), 86399);
    for (int k = 0; k < 20; k++) begin
      if (k == 3)  btn_inc = 1'b1;
      if (k == 11) btn_inc = 1'b0;
      cyc(1);
      chk("t5_stall_valid", 32'(load_valid), 1);
      chk("t5_stall_value", 32'(load_value), 86399);
      chk("t5_stall_sec",   32'(edit_sec),   59);
    end
    xb = xfers;
    load_ready = 1'b1;
    cyc(1);
    load_ready = 1'b0;
    chk("t5_drop_valid", 32'(load_valid), 0);
    chk("t5_drop_active", 32'(set_active), 0);
    chk("t5_keep_value", 32'(load_value), 86399);
    chk("t5_xfer", 32'(xfers - xb), 1);
    cyc(2);
    chk("t5_after_valid", 32'(load_valid), 0);

    // 6. Reset mid-session and mid-stall.
    cur_elapsed = 17'd3725;
    press(B_MODE, 8);
    chk("t6_in_set", 32'(edit_field), 1);
    reset = 1'b1;
    cyc(1);
    chk("t6a_valid",  32'(load_valid), 0);
    chk("t6a_active", 32'(set_active), 0);
    chk("t6a_field",  32'(edit_field), 0);
    chk("t6a_min",    32'(edit_min),   0);
    chk("t6a_sec",    32'(edit_sec),   0);
    chk("t6a_value",  32'(load_value), 0);
    reset = 1'b0;
    cyc(2);
    press(B_MODE, 8);
    press(B_MODE, 8);
    press(B_MODE, 8);
    chk("t6_in_load", 32'(load_valid), 1);
    xb = xfers;
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("t6b_valid",  32'(load_valid), 0);
    chk("t6b_active", 32'(set_active), 0);
    chk("t6b_value",  32'(load_value), 0);
    chk("t6b_min",    32'(edit_min),   0);
    cyc(5);
    chk("t6b_noxfer", 32'(xfers - xb), 0);
    chk("t6b_idle",   32'(load_valid), 0);

    chk("total_xfers", 32'(xfers), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- Input-side companion to the seconds-of-day clock: converts three raw push-buttons into a time-set session and delivers a new elapsed-seconds value to the clock counter over a valid/ready load handshake.
- Debounces and edge-detects the buttons, then runs a RUN / SET_MIN / SET_SEC / LOAD state machine.
- Exposes the edit fields and the currently edited field, so the display path can show and blink them.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000: cycles a synchronized button level must stay stable before it is accepted (20 ms at 50 MHz).
- TIMEOUT_CYCLES, 500_000_000: cycles with no accepted press in SET_MIN/SET_SEC before the session aborts (10 s at 50 MHz).

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- btn_mode  in  1  raw mode button, asynchronous, active-high.
- btn_inc  in  1  raw increment button, asynchronous, active-high.
- btn_dec  in  1  raw decrement button, asynchronous, active-high.
- cur_elapsed  in  17  current seconds of day from the clock, 0..86399.
- load_ready  in  1  clock counter accepts load this cycle.
- load_valid  out  1  new time is offered.
- load_value  out  17  new seconds of day, 0..86399.
- set_active  out  1  high in SET_MIN, SET_SEC or LOAD.
- edit_field  out  2  0 = none, 1 = minutes, 2 = seconds.
- edit_min  out  6  minutes being edited, 0..59.
- edit_sec  out  6  seconds being edited, 0..59.

Behaviour:
- Reset (clk edge with reset=1), all outputs 0:
  - state RUN, debounced levels 0, counters 0.
  - edit_min, edit_sec, captured hours, load_value, load_valid, set_active, edit_field all 0.
  - Reset mid-session or mid-LOAD aborts with no transfer.
- Input conditioning (each button independently):
  - 2-flop synchronizer.
  - Debounce counter clears whenever the synchronized level equals the debounced level; otherwise it increments.
  - When the counter has counted DEBOUNCE_CYCLES mismatching cycles, the debounced level flips and the counter clears.
  - Press = one-cycle pulse on a debounced 0->1 transition; release produces nothing.
  - Edit registers update D to D+4 cycles after a clean raw rising edge, where D = DEBOUNCE_CYCLES.
  - Glitches shorter than D cycles are never accepted.
- RUN (edit_field=0):
  - mode press: capture hours = cur_elapsed/3600, edit_min = (cur_elapsed/60)%60, edit_sec = cur_elapsed%60; go to SET_MIN.
  - inc/dec presses are ignored.
- SET_MIN (edit_field=1):
  - inc: edit_min +1, wrapping 59->0.
  - dec: edit_min -1, wrapping 0->59.
  - mode: go to SET_SEC.
- SET_SEC (edit_field=2):
  - inc/dec on edit_sec with the same wrap rules.
  - mode: go to LOAD with load_value = hours*3600 + edit_min*60 + edit_sec, registered on entry.
- Simultaneous presses in one cycle:
  - mode wins; inc/dec are dropped.
  - inc and dec together (without mode): no change.
- Timeout:
  - Counter clears on entering SET_MIN/SET_SEC and on every accepted press.
  - Reaching TIMEOUT_CYCLES returns to RUN with no load; edit values are held.
  - The timeout counter does not run in RUN or LOAD.
- LOAD (edit_field=2, set_active=1):
  - load_valid=1; load_value held stable until the transfer.
  - Transfer occurs on the cycle with load_valid & load_ready. The next cycle is RUN with load_valid=0.
  - If load_ready is already high on entry, load_valid is a single-cycle pulse.
  - All presses are ignored in LOAD; no timeout.
- Hours are never edited; the captured hour is preserved, so load_value is always < 86400.
- load_value keeps its last value after the transfer.

Test Plan (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=100):
1. Full edit session:
   - Stimulus: cur_elapsed=3725 (01:02:05); press mode; inc x3; mode; dec x6 (05->59 wrap); mode; load_ready held high.
   - Required: edit_min 02->05, edit_sec 05->59, one-cycle load_valid with load_value = 3600+300+59 = 3959, then RUN.
2. Glitch rejection:
   - Stimulus: btn_inc pulses of 1-3 cycles in SET_MIN.
   - Required: edit_min unchanged.
   - Follow-up: a 10-cycle press increments it exactly once, within 4-8 cycles of the raw edge.
3. Wrap and simultaneous presses:
   - In SET_MIN at 59, inc -> 0.
   - At 0, dec -> 59.
   - inc+dec asserted on the same cycle -> unchanged.
   - mode+inc together -> SET_SEC, edit_min unchanged.
4. Timeout:
   - Stimulus: enter SET_SEC, then no presses for 100 cycles.
   - Required: state RUN, set_active=0, edit_field=0, load_valid never asserted.
5. Handshake stall:
   - Stimulus: reach LOAD with load_ready=0 for 20 cycles; toggle inc during the stall; then raise load_ready for 1 cycle.
   - Required: load_valid high throughout with load_value constant, inc ignored, deassert the cycle after the transfer.
6. Reset mid-operation:
   - Stimulus: assert reset during SET_MIN and again during a LOAD stall.
   - Required: next cycle all outputs 0, state RUN, no transfer.
